// File: rtl/compuertas_pkg.sv
// rtl/compuertas_pkg.sv - shared types, gate bit positions and golden truth table for the gate prober
package compuertas_pkg;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    ESPERAR   = 2'd1,
    MUESTREAR = 2'd2,
    FIN       = 2'd3
  } estado_t;

  // Bit positions of each gate inside the 8-bit result bus
  localparam int BIT_AND  = 0;
  localparam int BIT_OR   = 1;
  localparam int BIT_XOR  = 2;
  localparam int BIT_NOT  = 3;
  localparam int BIT_NAND = 4;
  localparam int BIT_YES  = 5;
  localparam int BIT_NOR  = 6;
  localparam int BIT_XNOR = 7;

  // Expected outputs of a healthy gate unit; "not" follows operand A, "yes" follows operand B
  function automatic logic [7:0] golden(input logic a, input logic b);
    logic [7:0] g;
    g           = '0;
    g[BIT_AND]  = a & b;
    g[BIT_OR]   = a | b;
    g[BIT_XOR]  = a ^ b;
    g[BIT_NOT]  = ~a;
    g[BIT_NAND] = ~(a & b);
    g[BIT_YES]  = b;
    g[BIT_NOR]  = ~(a | b);
    g[BIT_XNOR] = ~(a ^ b);
    return g;
  endfunction

endpackage

// File: rtl/compuertas_probador_if.sv
// rtl/compuertas_probador_if.sv - control, status and gate-unit bus between the prober and its environment
interface compuertas_probador_if;

  logic       iniciar;
  logic [7:0] resultados;
  logic       entrada1;
  logic       entrada2;
  logic       ocupado;
  logic       listo;
  logic       aprobado;
  logic [7:0] mascara_error;
  logic [3:0] vector_fallido;

  // Prober side: drives operands and status, receives start and gate results
  modport master (
    input  iniciar,
    input  resultados,
    output entrada1,
    output entrada2,
    output ocupado,
    output listo,
    output aprobado,
    output mascara_error,
    output vector_fallido
  );

  // Environment side: issues start, returns gate results, observes status
  modport slave (
    output iniciar,
    output resultados,
    input  entrada1,
    input  entrada2,
    input  ocupado,
    input  listo,
    input  aprobado,
    input  mascara_error,
    input  vector_fallido
  );

endinterface

// File: rtl/compuertas_probador.sv
// rtl/compuertas_probador.sv - walks the four operand combinations through a gate unit and grades its outputs
module compuertas_probador
  import compuertas_pkg::*;
#(
  parameter int ESPERA = 1
) (
  input  logic                  reloj,
  input  logic                  reinicio_n,
  compuertas_probador_if.master bus
);

  if (ESPERA < 1 || ESPERA > 255) begin : g_espera_invalida
    $error("compuertas_probador: ESPERA must lie in 1..255");
  end

  localparam logic [7:0] CARGA = 8'(ESPERA - 1);

  estado_t    r_estado;
  estado_t    w_siguiente;
  logic [1:0] r_idx;
  logic [7:0] r_cnt;
  logic       r_e1;
  logic       r_e2;
  logic       r_aprobado;
  logic [7:0] r_mascara;
  logic [3:0] r_fallido;
  logic [7:0] w_diff;
  logic [1:0] w_idx_sig;
  logic       w_ocupado;
  logic       w_listo;

  // Results are only meaningful in MUESTREAR; elsewhere w_diff is ignored
  assign w_diff    = bus.resultados ^ golden(r_idx[1], r_idx[0]);
  assign w_idx_sig = r_idx + 2'd1;

  // State register
  always_ff @(posedge reloj or negedge reinicio_n) begin
    if (!reinicio_n) begin
      r_estado <= REPOSO;
    end else begin
      r_estado <= w_siguiente;
    end
  end

  // Next-state: settle for ESPERA cycles, sample once, repeat for four vectors, then one FIN cycle
  always_comb begin
    w_siguiente = r_estado;
    case (r_estado)
      REPOSO:    if (bus.iniciar) w_siguiente = ESPERAR;
      ESPERAR:   if (r_cnt == 8'd0) w_siguiente = MUESTREAR;
      MUESTREAR: w_siguiente = (r_idx == 2'd3) ? FIN : ESPERAR;
      FIN:       w_siguiente = REPOSO;
      default:   w_siguiente = REPOSO;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    w_ocupado = 1'b0;
    w_listo   = 1'b0;
    case (r_estado)
      ESPERAR, MUESTREAR: w_ocupado = 1'b1;
      FIN: begin
        w_ocupado = 1'b1;
        w_listo   = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand drive, settle counter and result accumulation
  always_ff @(posedge reloj or negedge reinicio_n) begin
    if (!reinicio_n) begin
      r_idx      <= 2'd0;
      r_cnt      <= 8'd0;
      r_e1       <= 1'b0;
      r_e2       <= 1'b0;
      r_aprobado <= 1'b0;
      r_mascara  <= 8'd0;
      r_fallido  <= 4'd0;
    end else begin
      case (r_estado)
        REPOSO: begin
          if (bus.iniciar) begin
            r_idx      <= 2'd0;
            r_cnt      <= CARGA;
            r_e1       <= 1'b0;
            r_e2       <= 1'b0;
            r_aprobado <= 1'b0;
            r_mascara  <= 8'd0;
            r_fallido  <= 4'd0;
          end
        end
        ESPERAR: begin
          if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        end
        MUESTREAR: begin
          r_mascara         <= r_mascara | w_diff;
          r_fallido[r_idx]  <= |w_diff;
          if (r_idx == 2'd3) begin
            // Grade on the mask including this last vector, so aprobado is valid alongside listo
            r_aprobado <= ((r_mascara | w_diff) == 8'd0);
          end else begin
            r_idx <= w_idx_sig;
            r_e1  <= w_idx_sig[1];
            r_e2  <= w_idx_sig[0];
            r_cnt <= CARGA;
          end
        end
        FIN: begin
          r_e1 <= 1'b0;
          r_e2 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.entrada1       = r_e1;
  assign bus.entrada2       = r_e2;
  assign bus.ocupado        = w_ocupado;
  assign bus.listo          = w_listo;
  assign bus.aprobado       = r_aprobado;
  assign bus.mascara_error  = r_mascara;
  assign bus.vector_fallido = r_fallido;

endmodule

// File: tb/tb_compuertas_probador.sv
// tb/tb_compuertas_probador.sv - scoreboard bench for the gate prober with healthy and faulty gate models
module tb_compuertas_probador;

  logic reloj = 1'b0;
  always #5 reloj = ~reloj;

  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  int   mode_a = 0;
  int   mode_b = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge reloj) cyc <= cyc + 1;

  compuertas_probador_if bus_a ();
  compuertas_probador_if bus_b ();

  compuertas_probador #(.ESPERA(1)) u_a (.reloj(reloj), .reinicio_n(rst_a), .bus(bus_a));
  compuertas_probador #(.ESPERA(3)) u_b (.reloj(reloj), .reinicio_n(rst_b), .bus(bus_b));

  // Gate unit model: 0 healthy, 1 and stuck-at-0, 2 yes wired to A (mode 3 is the lagged healthy unit)
  function automatic logic [7:0] unidad(input logic a, input logic b, input int mode);
    logic [7:0] r;
    r = {~(a ^ b), ~(a | b), b, ~(a & b), ~a, a ^ b, a | b, a & b};
    if (mode == 1) r[0] = 1'b0;
    if (mode == 2) r[5] = a;
    return r;
  endfunction

  logic [7:0] lag_a1, lag_a2, lag_b1, lag_b2;
  always @(posedge reloj) begin
    lag_a1 <= unidad(bus_a.entrada1, bus_a.entrada2, 0);
    lag_a2 <= lag_a1;
    lag_b1 <= unidad(bus_b.entrada1, bus_b.entrada2, 0);
    lag_b2 <= lag_b1;
  end

  assign bus_a.resultados = (mode_a == 3) ? lag_a2 : unidad(bus_a.entrada1, bus_a.entrada2, mode_a);
  assign bus_b.resultados = (mode_b == 3) ? lag_b2 : unidad(bus_b.entrada1, bus_b.entrada2, mode_b);

  typedef struct {
    int         cyc;
    logic       apr;
    logic [7:0] mask;
    logic [3:0] fail;
  } esperado_t;

  esperado_t q_a[$];
  esperado_t q_b[$];
  esperado_t e_mon_a;
  esperado_t e_mon_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge reloj) begin
    if (rst_a === 1'b1 && bus_a.listo === 1'b1) begin
      if (q_a.size() == 0) begin
        n_chk++;
        $display("FAIL listo_a_unexpected: got listo=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        e_mon_a = q_a.pop_front();
        chk("listo_a_cycle", cyc, e_mon_a.cyc);
        chk("ocupado_a_at_listo", bus_a.ocupado, 1);
        chk("aprobado_a", bus_a.aprobado, e_mon_a.apr);
        chk("mascara_a", bus_a.mascara_error, e_mon_a.mask);
        chk("fallido_a", bus_a.vector_fallido, e_mon_a.fail);
      end
    end
  end

  always @(negedge reloj) begin
    if (rst_b === 1'b1 && bus_b.listo === 1'b1) begin
      if (q_b.size() == 0) begin
        n_chk++;
        $display("FAIL listo_b_unexpected: got listo=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        e_mon_b = q_b.pop_front();
        chk("listo_b_cycle", cyc, e_mon_b.cyc);
        chk("ocupado_b_at_listo", bus_b.ocupado, 1);
        chk("aprobado_b", bus_b.aprobado, e_mon_b.apr);
        chk("mascara_b", bus_b.mascara_error, e_mon_b.mask);
        chk("fallido_b", bus_b.vector_fallido, e_mon_b.fail);
      end
    end
  end

  task automatic empujar(input int which, input int c, input logic apr, input logic [7:0] m, input logic [3:0] f);
    esperado_t e;
    e.cyc = c; e.apr = apr; e.mask = m; e.fail = f;
    if (which == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  // One-cycle start pulse; listo is due 4*(ESPERA+1) edges after the start edge
  task automatic arrancar(input int which, input logic apr, input logic [7:0] m, input logic [3:0] f, output int k);
    @(negedge reloj);
    if (which == 0) bus_a.iniciar = 1'b1;
    else bus_b.iniciar = 1'b1;
    k = cyc + 1;
    empujar(which, k + ((which == 0) ? 8 : 16), apr, m, f);
    @(negedge reloj);
    if (which == 0) bus_a.iniciar = 1'b0;
    else bus_b.iniciar = 1'b0;
  endtask

  task automatic esperar_fin(input int which);
    int n;
    n = 0;
    while (((which == 0) ? q_a.size() : q_b.size()) != 0 && n < 100) begin
      @(negedge reloj);
      #1;
      n++;
    end
    if (((which == 0) ? q_a.size() : q_b.size()) != 0) begin
      n_chk++;
      $display("FAIL timeout_%0d: got no listo expected listo within 100 cycles", which);
      if (which == 0) q_a.delete();
      else q_b.delete();
    end
    @(negedge reloj);
    if (which == 0) begin
      chk("idle_ocupado_a", bus_a.ocupado, 0);
      chk("idle_entrada1_a", bus_a.entrada1, 0);
      chk("idle_entrada2_a", bus_a.entrada2, 0);
    end else begin
      chk("idle_ocupado_b", bus_b.ocupado, 0);
      chk("idle_entrada1_b", bus_b.entrada1, 0);
      chk("idle_entrada2_b", bus_b.entrada2, 0);
    end
  endtask

  task automatic chk_cero_a(input string tag);
    chk({tag, "_ocupado"}, bus_a.ocupado, 0);
    chk({tag, "_listo"}, bus_a.listo, 0);
    chk({tag, "_aprobado"}, bus_a.aprobado, 0);
    chk({tag, "_mascara"}, bus_a.mascara_error, 0);
    chk({tag, "_fallido"}, bus_a.vector_fallido, 0);
    chk({tag, "_entrada1"}, bus_a.entrada1, 0);
    chk({tag, "_entrada2"}, bus_a.entrada2, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    int k;
    int pulsos[3];
    pulsos = '{3, 6, 8};
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.iniciar = 1'b0;
    bus_b.iniciar = 1'b0;
    repeat (3) @(negedge reloj);
    chk_cero_a("reset");
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge reloj);

    // Healthy unit
    arrancar(0, 1'b1, 8'h00, 4'b0000, k);
    esperar_fin(0);

    // and stuck-at-0: only vector 3 (A3 vs A2)
    mode_a = 1;
    arrancar(0, 1'b0, 8'h01, 4'b1000, k);
    esperar_fin(0);
    repeat (5) @(negedge reloj);
    chk("hold_mascara", bus_a.mascara_error, 8'h01);
    chk("hold_fallido", bus_a.vector_fallido, 4'b1000);

    // yes follows A: vectors 1 and 2 differ
    mode_a = 2;
    arrancar(0, 1'b0, 8'h20, 4'b0110, k);
    esperar_fin(0);

    // iniciar held high: runs every 10 cycles, results cleared at start
    mode_a = 0;
    @(negedge reloj);
    bus_a.iniciar = 1'b1;
    k = cyc + 1;
    empujar(0, k + 8, 1'b1, 8'h00, 4'b0000);
    empujar(0, k + 18, 1'b1, 8'h00, 4'b0000);
    @(negedge reloj);
    chk("clear_mascara", bus_a.mascara_error, 8'h00);
    chk("clear_fallido", bus_a.vector_fallido, 4'b0000);
    chk("clear_ocupado", bus_a.ocupado, 1);
    while (cyc < k + 10) @(negedge reloj);
    bus_a.iniciar = 1'b0;
    esperar_fin(0);

    // Start pulses during a run are ignored
    arrancar(0, 1'b1, 8'h00, 4'b0000, k);
    foreach (pulsos[i]) begin
      while (cyc < k + pulsos[i] - 1) @(negedge reloj);
      bus_a.iniciar = 1'b1;
      @(negedge reloj);
      bus_a.iniciar = 1'b0;
    end
    esperar_fin(0);
    repeat (12) @(negedge reloj);

    // Reset during vector 2 settle
    mode_a = 2;
    arrancar(0, 1'b0, 8'h20, 4'b0110, k);
    while (cyc < k + 4) @(negedge reloj);
    chk("v2_entrada1", bus_a.entrada1, 1);
    chk("v2_entrada2", bus_a.entrada2, 0);
    chk("v2_mascara", bus_a.mascara_error, 8'h20);
    rst_a = 1'b0;
    #1;
    q_a.delete();
    chk_cero_a("async_reset");
    repeat (2) @(negedge reloj);
    rst_a = 1'b1;
    mode_a = 0;
    repeat (2) @(negedge reloj);
    arrancar(0, 1'b1, 8'h00, 4'b0000, k);
    esperar_fin(0);

    // Outputs lagging two cycles: ESPERA=3 absorbs it
    mode_b = 3;
    repeat (3) @(negedge reloj);
    arrancar(1, 1'b1, 8'h00, 4'b0000, k);
    esperar_fin(1);

    // ESPERA=1 samples the previous vector: diffs E6, 28, B5
    mode_a = 3;
    repeat (3) @(negedge reloj);
    arrancar(0, 1'b0, 8'hFF, 4'b1110, k);
    esperar_fin(0);

    repeat (3) @(negedge reloj);
    chk("hold_aprobado_b", bus_b.aprobado, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/compuertas_probador.md
Name: compuertas_probador

Overview:
Self-checking stimulus/capture sequencer for the two-input gate unit. It drives entrada1/entrada2 through all four input combinations and waits a programmable settle time per vector. It then samples the unit's eight gate outputs and compares them against a built-in golden truth table. It reports pass/fail, a per-gate error mask and a per-vector failure map.

Parameters:
ESPERA, 1, settle cycles between applying a vector and sampling results; legal range 1..255

Ports:
reloj  input  1  single clock, rising-edge
reinicio_n  input  1  asynchronous active-low reset
iniciar  input  1  start request; sampled only in REPOSO
resultados  input  8  gate outputs from unit under test: [0]and [1]or [2]xor [3]not [4]nand [5]yes [6]nor [7]xnor
entrada1  output  1  operand A driven to unit under test (registered)
entrada2  output  1  operand B driven to unit under test (registered)
ocupado  output  1  high from the cycle after start through the FIN cycle
listo  output  1  one-cycle completion pulse
aprobado  output  1  1 when the last run had zero mismatches; valid from listo until next start
mascara_error  output  8  sticky OR of mismatching gate bits across all vectors of the last run
vector_fallido  output  4  bit i set if vector i had any mismatch

Behaviour:
- Reset: reloj is the only clock. reinicio_n is asynchronous, active-low, and forces every output to 0 and the FSM to REPOSO immediately, including mid-run. No partial results survive reset.
- Vector order: idx 0..3, with entrada1=idx[1] and entrada2=idx[0].
- Golden values, packed [7:0]: 00 -> 0xD8, 01 -> 0x3E, 10 -> 0x16, 11 -> 0xA3.
  - not = ~entrada1
  - yes = entrada2
  - remaining bits are the standard functions of entrada1, entrada2.
- FSM states: REPOSO, ESPERAR, MUESTREAR, FIN.
- REPOSO:
  - If iniciar=1 at a clock edge: clear mascara_error, vector_fallido and aprobado; set idx=0.
  - Drive entrada1/entrada2 = vector 0, load the wait counter with ESPERA-1, set ocupado=1, go to ESPERAR.
- ESPERAR: hold the inputs. Decrement the counter; at 0 go to MUESTREAR. The state lasts exactly ESPERA cycles.
- MUESTREAR (1 cycle): compute diff = resultados XOR golden(idx).
  - mascara_error |= diff.
  - vector_fallido[idx] = |diff.
  - If idx==3 go to FIN. Otherwise idx++, drive the next vector, reload the counter, go to ESPERAR.
- FIN (1 cycle): listo=1, aprobado = (mascara_error==0), ocupado=1. Next state is REPOSO (ocupado=0, listo=0).
- Latency: for iniciar sampled at edge k, listo is high during the cycle following edge k+4*(ESPERA+1). The FSM is back in REPOSO after one more edge.
- Restart period with iniciar held high: 4*(ESPERA+1)+2 cycles.
- iniciar while ocupado=1 is ignored, not queued.
- Results (aprobado, mascara_error, vector_fallido) hold after FIN until the next accepted start or reset.
- entrada1/entrada2 return to 0 in REPOSO after FIN.
- resultados is sampled only in MUESTREAR. Values during ESPERAR are don't-care (X-tolerant).
- Counter width: 8 bits. Compile-time check ESPERA in 1..255.

Decomposition:
- Package compuertas_pkg:
  - state enum (REPOSO, ESPERAR, MUESTREAR, FIN)
  - gate bit-index constants (BIT_AND..BIT_XNOR)
  - function golden(a,b) returning the 8-bit expected vector
- No sub-module; the settle counter and compare stay inline. The unit under test is instantiated only in the bench.

Test Plan:
- Correct gate model, ESPERA=1, pulse iniciar -> listo 8 cycles after start edge, aprobado=1, mascara_error=0x00, vector_fallido=4'b0000.
- Model with and stuck-at-0 -> only vector 3 fails: mascara_error=0x01, vector_fallido=4'b1000, aprobado=0.
- Model with yes wired to entrada1 -> mascara_error=0x20, vector_fallido=4'b0110, aprobado=0.
- iniciar held high, ESPERA=1 -> listo pulses every 10 cycles; extra iniciar pulses during a run have no effect; results cleared at each start.
- Assert reinicio_n=0 during vector 2 ESPERAR -> all outputs 0 asynchronously (before next edge); after release, one iniciar gives a full clean run with correct results.
- Model whose outputs lag inputs by 2 cycles: ESPERA=3 -> aprobado=1; ESPERA=1 -> aprobado=0 with vector_fallido nonzero.
